// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder, CHUNK bits per clock, LSB chunk first.
// Ports: clk, rst (async high), start/busy/done handshake,
//   a, b, cin operands; sum, cout result held until next accepted start.
// Option SERIAL_ADDER_SUB_EN adds input sub (a - b) and output ovf.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
   output logic             ovf,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CH = (CHUNK < 1) ? 1 : CHUNK;
   localparam int N  = WIDTH / CH;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   generate
      if (CHUNK < 1 || (WIDTH % CH) != 0) begin : g_bad_cfg
         $error("serial_adder: WIDTH must be a multiple of CHUNK >= 1");
      end
   endgenerate

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;

`ifdef SERIAL_ADDER_SUB_EN
   logic             sub_q, sub_d;
   logic             ovf_q, ovf_d;
   logic             msb_cin;
`else
   logic             sub_q;
   assign sub_q = 1'b0;
`endif

   logic [CH-1:0]    chunk_a;
   logic [CH-1:0]    chunk_b;
   logic [CH:0]      add_r;
   logic [WIDTH-1:0] s_ext;
   logic [WIDTH-1:0] acc_next;
   logic             last;

   // B is inverted per chunk for subtraction; carry seed supplies the +1.
   assign chunk_a  = a_q[CH-1:0];
   assign chunk_b  = b_q[CH-1:0] ^ {CH{sub_q}};
   assign add_r    = {1'b0, chunk_a} + {1'b0, chunk_b}
                   + (CH+1)'(carry_q);
   assign s_ext    = WIDTH'(add_r[CH-1:0]);
   // New chunk enters from the MSB side so the LSB chunk ends at bit 0.
   assign acc_next = (acc_q >> CH) | (s_ext << (WIDTH - CH));
   assign last     = (cnt_q == CW'(N - 1));

`ifdef SERIAL_ADDER_SUB_EN
   // Carry into the MSB recovered from the MSB bit's own sum.
   assign msb_cin = chunk_a[CH-1] ^ chunk_b[CH-1] ^ add_r[CH-1];
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_SUB_EN
      sub_d   = sub_q;
      ovf_d   = ovf_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               state_d = S_RUN;
               a_d     = a;
               b_d     = b;
               acc_d   = '0;
               cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
               sub_d   = sub;
               carry_d = sub ? 1'b1 : cin;
`else
               carry_d = cin;
`endif
            end
         end
         S_RUN: begin
            a_d     = a_q >> CH;
            b_d     = b_q >> CH;
            acc_d   = acc_next;
            carry_d = add_r[CH];
            cnt_d   = cnt_q + CW'(1);
            if (last) begin
               state_d = S_DONE;
               sum_d   = acc_next;
               cout_d  = add_r[CH];
`ifdef SERIAL_ADDER_SUB_EN
               ovf_d   = msb_cin ^ add_r[CH];
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
         sub_q   <= 1'b0;
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_SUB_EN
         sub_q   <= sub_d;
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADDER_SUB_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: bench for serial_adder, CHUNK=1 and CHUNK=4 instances.
// Table vectors plus hand sequences; results checked via scoreboard queues.
module tb_serial_adder;

   typedef struct packed {
      logic [7:0] s;
      logic       co;
      logic       ov;
   } exp_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] s;
      logic       co;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start0 = 1'b0;
   logic       start4 = 1'b0;
   logic [7:0] a_i = 8'h00;
   logic [7:0] b_i = 8'h00;
   logic       cin_i = 1'b0;
   logic       busy0, done0, cout0;
   logic       busy4, done4, cout4;
   logic [7:0] sum0, sum4;
`ifdef SERIAL_ADDER_SUB_EN
   logic       sub_i = 1'b0;
   logic       ovf0, ovf4;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   exp_t q0[$];
   exp_t q4[$];
   exp_t me;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8), .CHUNK(1)) dut0 (
      .clk(clk), .rst(rst), .start(start0),
      .a(a_i), .b(b_i), .cin(cin_i),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub_i), .ovf(ovf0),
`endif
      .busy(busy0), .done(done0), .sum(sum0), .cout(cout0)
   );

   serial_adder #(.WIDTH(8), .CHUNK(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4),
      .a(a_i), .b(b_i), .cin(cin_i),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub_i), .ovf(ovf4),
`endif
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: pop one expectation per done pulse.
   always @(negedge clk) begin
      if (!rst && done0) begin
         if (q0.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut0_unexpected_done: got done=1 expected 0");
         end else begin
            me = q0.pop_front();
            chk("dut0_sum", 32'(sum0), 32'(me.s));
            chk("dut0_cout", 32'(cout0), 32'(me.co));
`ifdef SERIAL_ADDER_SUB_EN
            chk("dut0_ovf", 32'(ovf0), 32'(me.ov));
`endif
         end
      end
      if (!rst && done4) begin
         if (q4.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut4_unexpected_done: got done=1 expected 0");
         end else begin
            me = q4.pop_front();
            chk("dut4_sum", 32'(sum4), 32'(me.s));
            chk("dut4_cout", 32'(cout4), 32'(me.co));
`ifdef SERIAL_ADDER_SUB_EN
            chk("dut4_ovf", 32'(ovf4), 32'(me.ov));
`endif
         end
      end
   end

   // Drive a request at a negedge, push its expectation, step one cycle.
   task automatic launch(input bit w4, input logic [7:0] av,
                         input logic [7:0] bv, input logic c,
                         input logic s, input logic [7:0] es,
                         input logic eco, input logic eov,
                         input bit hold);
      exp_t e;
      a_i   = av;
      b_i   = bv;
      cin_i = c;
`ifdef SERIAL_ADDER_SUB_EN
      sub_i = s;
`endif
      e.s  = es;
      e.co = eco;
      e.ov = eov | (s & 1'b0);
      if (w4) begin
         start4 = 1'b1;
         q4.push_back(e);
      end else begin
         start0 = 1'b1;
         q0.push_back(e);
      end
      @(negedge clk);
      if (!hold) begin
         start0 = 1'b0;
         start4 = 1'b0;
      end
   endtask

   // Entered at the first negedge after the accepting edge.
   task automatic wait_done(input bit w4, input int exp_lat,
                            input string name);
      int lat;
      logic [7:0] held;
      bit moved;
      lat   = 1;
      moved = 1'b0;
      held  = w4 ? sum4 : sum0;
      chk({name, "_busy"}, 32'(w4 ? busy4 : busy0), 32'd1);
      while (!(w4 ? done4 : done0) && lat < 40) begin
         if ((w4 ? sum4 : sum0) !== held) moved = 1'b1;
         @(negedge clk);
         lat++;
      end
      chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({name, "_no_partial"}, 32'(moved), 32'd0);
   endtask

   vec_t tbl[4];

   initial begin
      logic [8:0] m;
      logic [7:0] ra, rb;
      logic       rc;

      tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
      tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      tbl[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
      tbl[3] = '{8'h7F, 8'h80, 1'b1, 8'h00, 1'b1};

      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_sum", 32'(sum0), 32'd0);
      chk("rst_cout", 32'(cout0), 32'd0);
      chk("rst_sum4", 32'(sum4), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         launch(1'b0, tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0,
                tbl[i].s, tbl[i].co, 1'b0, 1'b0);
         wait_done(1'b0, 9, "tbl");
         @(negedge clk);
         chk("tbl_done_pulse", 32'(done0), 32'd0);
         chk("tbl_sum_hold", 32'(sum0), 32'(tbl[i].s));
         chk("tbl_cout_hold", 32'(cout0), 32'(tbl[i].co));
      end

      for (int i = 0; i < 4; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rc = 1'($urandom_range(0, 1));
         m  = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
         launch(1'b0, ra, rb, rc, 1'b0, m[7:0], m[8], 1'b0, 1'b0);
         wait_done(1'b0, 9, "rnd");
         @(negedge clk);
      end

      // start held with new operands during RUN, then accepted in DONE.
      launch(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b0, 1'b1);
      a_i   = 8'hFF;
      b_i   = 8'hFF;
      cin_i = 1'b1;
      wait_done(1'b0, 9, "ign");
      q0.push_back('{s: 8'hFF, co: 1'b1, ov: 1'b0});
      @(negedge clk);
      start0 = 1'b0;
      wait_done(1'b0, 9, "b2b");
      @(negedge clk);

      // Reset in RUN cycle 4 clears outputs without a clock edge.
      launch(1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy0), 32'd0);
      chk("mid_rst_done", 32'(done0), 32'd0);
      chk("mid_rst_sum", 32'(sum0), 32'd0);
      chk("mid_rst_cout", 32'(cout0), 32'd0);
      q0.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      launch(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0);
      wait_done(1'b0, 9, "post_rst");
      @(negedge clk);

      // CHUNK=4 instance: two edges per add.
      launch(1'b1, 8'hAB, 8'h55, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      wait_done(1'b1, 3, "c4");
      @(negedge clk);
      launch(1'b1, 8'h5A, 8'h3C, 1'b1, 1'b0, 8'h97, 1'b0, 1'b0, 1'b0);
      wait_done(1'b1, 3, "c4b");
      @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
      launch(1'b0, 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
      wait_done(1'b0, 9, "sub1");
      @(negedge clk);
      launch(1'b0, 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
      wait_done(1'b0, 9, "sub_cin");
      @(negedge clk);
      launch(1'b0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
      wait_done(1'b0, 9, "sub2");
      @(negedge clk);
      launch(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
      wait_done(1'b0, 9, "add_ovf");
      @(negedge clk);
      launch(1'b1, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
      wait_done(1'b1, 3, "c4_sub");
      @(negedge clk);
`endif

      repeat (2) @(negedge clk);
      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q4_drained", 32'(q4.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
